i2c_target_rx: RTL and testbench
================================

Name: i2c_target_rx

Overview:
- Write-only I2C target (peripheral) on the shared open-drain bus, directly downstream of I2C_controller.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Receives 7-bit address + R/W, compares the address to a parameter and ACKs on a match.
- Receives data bytes, ACKs each one and presents it to local logic with a one-cycle valid strobe.

Parameters:
- ADDR, 7'h2A, target address this instance responds to.
- SYNC_STAGES, 2, synchronizer depth on i2c_scl/i2c_sda (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- reset  input  1  asynchronous, active-low reset.
- i2c_scl  input  1  bus clock (target never stretches).
- i2c_sda  inout  1  bus data; driven 0 or released to Z only, never driven 1.
- rx_data  output  8  last received data byte, held until the next byte completes.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- addr_hit  output  1  one-clk pulse on address match with R/W=0.
- busy  output  1  high from a matched address until STOP, START or reset.
- byte_count  output  8  data bytes received in the current transaction; saturates at 255.

Behaviour:
- Reset (reset=0, async): SDA released, rx_data=0, rx_valid=0, addr_hit=0, busy=0, byte_count=0, state=IDLE, shift register cleared. Takes effect immediately, including mid-byte or mid-ACK.
- Sampling:
  - SCL/SDA pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - All bus events are seen SYNC_STAGES+1 clks after the pin change.
- Bus events:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on SCL rising; SDA is changed only on SCL falling.
- State machine: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: START -> ADDR; bit counter=0.
  - ADDR: shift 8 bits MSB first on SCL rising. After the 8th bit:
    - address==ADDR and R/W=0 -> ADDR_ACK, pulse addr_hit.
    - otherwise -> IGNORE (no ACK, SDA stays released).
  - ADDR_ACK: on the next SCL falling, drive SDA low and set busy=1. Hold through the 9th SCL high. Release on the following SCL falling -> DATA.
  - DATA: shift 8 bits on SCL rising. On the 8th rising edge:
    - rx_data <= shifted byte.
    - rx_valid pulses in the next clk.
    - byte_count increments (saturating).
    - go to DATA_ACK.
  - DATA_ACK: same ACK timing as ADDR_ACK, then back to DATA for the next byte.
  - IGNORE: passive until START or STOP.
- Global transitions:
  - START in any state (repeated start): release SDA, byte_count=0, busy=0, go to ADDR.
  - STOP in any state: release SDA, busy=0, go to IDLE; rx_data and byte_count hold until the next START.
- Partial byte cut by START/STOP: discarded, no rx_valid.
- Simultaneous STOP and 8th-bit edge: impossible on a legal bus; STOP takes priority.
- rx_valid and addr_hit never assert in the same cycle.

Decomposition:
- Shared package i2c_pkg:
  - state encoding (enum IDLE..IGNORE).
  - constants I2C_ADDR_W=7, I2C_DATA_W=8, ACK=1'b0, NACK=1'b1.
  - I2C_controller reuses the width and ACK constants.
- One natural sub-module, i2c_bus_sync:
  - SYNC_STAGES synchronizer plus edge detector.
  - outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
  - reusable by every peripheral.

Test Plan:
- START, addr 0x2A+W, data 0xAA, STOP:
  - SDA low during the 9th SCL high of both the address and data phases.
  - addr_hit pulses once.
  - rx_data=0xAA with one rx_valid pulse.
  - byte_count=1; busy falls after STOP.
- START, addr 0x49+W, data 0x66, STOP: SDA never driven low by the target; addr_hit, rx_valid and busy stay 0; byte_count=0.
- Addr 0x2A+W, data 0x66 then 0x99, STOP: two rx_valid pulses with rx_data 0x66 then 0x99; two data ACKs; byte_count=2.
- Addr 0x2A+R: no ACK, state IGNORE, busy=0; the next write to 0x2A with data 0x5A is accepted normally.
- Reset low after 4 bits of data byte 0x99:
  - SDA released within the same clk.
  - All outputs return to reset values.
  - The following full write of 0x2A/0x3C gives rx_data=0x3C.
- Repeated START after address ACK and 3 data bits, then addr 0x2A+W, data 0xC3:
  - partial byte discarded; byte_count resets to 0 then reaches 1.
  - rx_data=0xC3.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, field widths
// and ACK/NACK bus levels.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge and START/STOP detection.
// Ports: clk, reset (async, active-low), scl, sda in;
// scl_rise, scl_fall, start_det, stop_det, sda_s out.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_s;
  logic                   scl_q;
  logic                   sda_q;

  // Reset to the idle bus level so leaving reset
  // does not fake an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  assign scl_s = scl_sr[SYNC_STAGES-1];
  assign sda_s = sda_sr[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SCL must be high on both samples around the SDA edge.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: matches ADDR, ACKs address and data,
// presents bytes on rx_data/rx_valid, counts bytes per transfer.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h2A,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  output logic [I2C_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  addr_hit,
  output logic                  busy,
  output logic [7:0]            byte_count
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (i2c_scl),
    .sda       (i2c_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e            state, state_n;
  logic [2:0]            bit_cnt, bit_cnt_n;
  logic [I2C_DATA_W-1:0] shreg, shreg_n;
  logic [I2C_DATA_W-1:0] shifted;
  logic [I2C_DATA_W-1:0] rx_data_n;
  logic [7:0]            byte_cnt_n;
  logic                  sda_oe, sda_oe_n;
  logic                  ack_drv, ack_drv_n;
  logic                  busy_n;
  logic                  rx_valid_n;
  logic                  addr_hit_n;

  // Open drain: only ever pull low.
  assign i2c_sda = sda_oe ? ACK : 1'bz;

  assign shifted = {shreg[I2C_DATA_W-2:0], sda_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_oe     <= 1'b0;
      ack_drv    <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      addr_hit   <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      sda_oe     <= sda_oe_n;
      ack_drv    <= ack_drv_n;
      busy       <= busy_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      addr_hit   <= addr_hit_n;
      byte_count <= byte_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    sda_oe_n   = sda_oe;
    ack_drv_n  = ack_drv;
    busy_n     = busy;
    rx_data_n  = rx_data;
    byte_cnt_n = byte_count;
    rx_valid_n = 1'b0;
    addr_hit_n = 1'b0;

    if (stop_det) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      shreg_n   = '0;
      sda_oe_n  = 1'b0;
      ack_drv_n = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n    = ST_ADDR;
      bit_cnt_n  = '0;
      shreg_n    = '0;
      sda_oe_n   = 1'b0;
      ack_drv_n  = 1'b0;
      busy_n     = 1'b0;
      byte_cnt_n = '0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_n   = shifted;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shifted[7:1] == ADDR && !shifted[0]) begin
                state_n    = ST_ADDR_ACK;
                addr_hit_n = 1'b1;
              end else begin
                state_n = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          // First fall: pull SDA for the 9th clock.
          // Second fall: let go and receive the next byte.
          if (scl_fall) begin
            if (!ack_drv) begin
              sda_oe_n  = 1'b1;
              ack_drv_n = 1'b1;
              busy_n    = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              ack_drv_n = 1'b0;
              bit_cnt_n = '0;
              state_n   = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (scl_rise) begin
            shreg_n   = shifted;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_n  = shifted;
              rx_valid_n = 1'b1;
              if (byte_count != 8'hFF)
                byte_cnt_n = byte_count + 8'd1;
              state_n = ST_DATA_ACK;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged controller
// with a passive pulse monitor.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_hit;
  logic       busy;
  logic [7:0] byte_count;

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  i2c_target_rx #(
    .ADDR(7'h2A),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i2c_scl    (scl),
    .i2c_sda    (sda_bus),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .addr_hit   (addr_hit),
    .busy       (busy),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         hit_cnt = 0;
  int         val_cnt = 0;
  int         tgt_low = 0;
  int         both_cnt = 0;
  logic [7:0] rx_log [0:3];

  always @(negedge clk) begin
    if (addr_hit) hit_cnt++;
    if (rx_valid) begin
      if (val_cnt < 4) rx_log[val_cnt] = rx_data;
      val_cnt++;
    end
    if (addr_hit && rx_valid) both_cnt++;
    if (m_sda && sda_bus === 1'b0) tgt_low++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_mon();
    hit_cnt  = 0;
    val_cnt  = 0;
    tgt_low  = 0;
    both_cnt = 0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(10);
    scl   = 1'b1; tick(10);
    m_sda = 1'b0; tick(10);
    scl   = 1'b0; tick(10);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(10);
    scl   = 1'b1; tick(10);
    m_sda = 1'b1; tick(10);
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b;    tick(10);
    scl   = 1'b1; tick(20);
    scl   = 1'b0; tick(10);
  endtask

  task automatic wr_byte(input logic [7:0] b,
                         output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(b[i]);
    m_sda = 1'b1; tick(10);
    scl   = 1'b1; tick(10);
    ack   = sda_bus;
    tick(10);
    scl   = 1'b0; tick(10);
  endtask

  logic ack;

  initial begin
    tick(5);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_byte_count", byte_count, 8'h00);
    chk("rst_sda", sda_bus, 1'b1);
    reset = 1'b1;
    tick(10);

    // 0x2A write, 0xAA
    clr_mon();
    i2c_start();
    wr_byte(8'h54, ack);
    chk("t1_addr_ack", ack, 1'b0);
    chk("t1_busy", busy, 1'b1);
    wr_byte(8'hAA, ack);
    chk("t1_data_ack", ack, 1'b0);
    chk("t1_rx_data", rx_data, 8'hAA);
    chk("t1_byte_count", byte_count, 8'd1);
    i2c_stop();
    chk("t1_busy_stop", busy, 1'b0);
    chk("t1_cnt_hold", byte_count, 8'd1);
    chk("t1_hits", hit_cnt, 1);
    chk("t1_valids", val_cnt, 1);

    // 0x49 write, not ours
    clr_mon();
    i2c_start();
    wr_byte(8'h92, ack);
    chk("t2_addr_nack", ack, 1'b1);
    chk("t2_busy", busy, 1'b0);
    wr_byte(8'h66, ack);
    chk("t2_data_nack", ack, 1'b1);
    i2c_stop();
    chk("t2_tgt_low", tgt_low, 0);
    chk("t2_hits", hit_cnt, 0);
    chk("t2_valids", val_cnt, 0);
    chk("t2_byte_count", byte_count, 8'd0);

    // two bytes
    clr_mon();
    i2c_start();
    wr_byte(8'h54, ack);
    chk("t3_addr_ack", ack, 1'b0);
    wr_byte(8'h66, ack);
    chk("t3_ack0", ack, 1'b0);
    wr_byte(8'h99, ack);
    chk("t3_ack1", ack, 1'b0);
    i2c_stop();
    chk("t3_valids", val_cnt, 2);
    chk("t3_rx0", rx_log[0], 8'h66);
    chk("t3_rx1", rx_log[1], 8'h99);
    chk("t3_byte_count", byte_count, 8'd2);

    // read request is ignored, next write accepted
    clr_mon();
    i2c_start();
    wr_byte(8'h55, ack);
    chk("t4_read_nack", ack, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_hits", hit_cnt, 0);
    wr_byte(8'h12, ack);
    chk("t4_ign_nack", ack, 1'b1);
    i2c_stop();
    i2c_start();
    wr_byte(8'h54, ack);
    chk("t4_addr_ack", ack, 1'b0);
    wr_byte(8'h5A, ack);
    chk("t4_data_ack", ack, 1'b0);
    i2c_stop();
    chk("t4_rx_data", rx_data, 8'h5A);
    chk("t4_valids", val_cnt, 1);

    // reset after 4 data bits
    clr_mon();
    i2c_start();
    wr_byte(8'h54, ack);
    chk("t5_addr_ack", ack, 1'b0);
    wr_bit(1'b1);
    wr_bit(1'b0);
    wr_bit(1'b0);
    wr_bit(1'b1);
    chk("t5_busy_pre", busy, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t5_sda", sda_bus, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_byte_count", byte_count, 8'h00);
    chk("t5_pulses", {rx_valid, addr_hit}, 2'b00);
    scl   = 1'b1;
    m_sda = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(10);
    clr_mon();
    i2c_start();
    wr_byte(8'h54, ack);
    chk("t5_re_addr_ack", ack, 1'b0);
    wr_byte(8'h3C, ack);
    chk("t5_re_data_ack", ack, 1'b0);
    i2c_stop();
    chk("t5_re_rx_data", rx_data, 8'h3C);
    chk("t5_re_valids", val_cnt, 1);

    // repeated START mid-byte
    clr_mon();
    i2c_start();
    wr_byte(8'h54, ack);
    chk("t6_addr_ack", ack, 1'b0);
    chk("t6_busy_pre", busy, 1'b1);
    wr_bit(1'b1);
    wr_bit(1'b1);
    wr_bit(1'b0);
    i2c_start();
    chk("t6_busy_rs", busy, 1'b0);
    chk("t6_cnt_rs", byte_count, 8'd0);
    chk("t6_no_valid", val_cnt, 0);
    wr_byte(8'h54, ack);
    chk("t6_addr2_ack", ack, 1'b0);
    wr_byte(8'hC3, ack);
    chk("t6_data_ack", ack, 1'b0);
    i2c_stop();
    chk("t6_rx_data", rx_data, 8'hC3);
    chk("t6_byte_count", byte_count, 8'd1);
    chk("t6_hits", hit_cnt, 2);
    chk("t6_valids", val_cnt, 1);
    chk("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
